// File: rtl/sbox_arbiter.sv
// Purpose : shares one 4-byte S-box ROM between sub_bytes (SB) and key expansion (KE).
// Latency : grant is combinational; result returns LATENCY+1 edges after the grant edge (rvalid registered).
// Backpres: a requester holds req/addr until gnt; results have no backpressure (one-cycle rvalid pulse).
//
// Ports:
//   clk, rst             - clock, asynchronous active-low reset
//   sb_req/addr/gnt      - sub_bytes request side; sb_rvalid/sb_rdata its result
//   ke_req/addr/gnt      - key expansion request side; ke_rvalid/ke_rdata its result
//   rom_en/addr/data     - shared S-box ROM; rom_data valid LATENCY cycles after rom_en
//   busy                 - at least one lookup in flight
//
// Build option: define SBOX_ARB_KE_PRIORITY_EN to give KE fixed priority on
// contention; otherwise the two ports are served round-robin.
// LATENCY must be 1..4.
module sbox_arbiter #(
    parameter int LATENCY = 1,
    parameter int W       = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sb_req,
    input  logic [W-1:0] sb_addr,
    output logic         sb_gnt,
    output logic         sb_rvalid,
    output logic [W-1:0] sb_rdata,
    input  logic         ke_req,
    input  logic [W-1:0] ke_addr,
    output logic         ke_gnt,
    output logic         ke_rvalid,
    output logic [W-1:0] ke_rdata,
    output logic         rom_en,
    output logic [W-1:0] rom_addr,
    input  logic [W-1:0] rom_data,
    output logic         busy
);

    typedef enum logic {
        OWN_SB = 1'b0,
        OWN_KE = 1'b1
    } owner_t;

    // Tag pipeline: one {valid, owner} pair per cycle of ROM latency.
    logic [LATENCY-1:0] tag_vld;
    logic [LATENCY-1:0] tag_own;   // 1 = KE owns the lookup

`ifndef SBOX_ARB_KE_PRIORITY_EN
    owner_t last_gnt;
`endif

    // Grant: a lone requester always wins; contention is resolved either by
    // fixed KE priority or by handing the slot to whoever did not win last.
    always_comb begin
        sb_gnt = 1'b0;
        ke_gnt = 1'b0;
        if (sb_req && !ke_req) begin
            sb_gnt = 1'b1;
        end else if (ke_req && !sb_req) begin
            ke_gnt = 1'b1;
        end else if (sb_req && ke_req) begin
`ifdef SBOX_ARB_KE_PRIORITY_EN
            ke_gnt = 1'b1;
`else
            if (last_gnt == OWN_SB) begin
                ke_gnt = 1'b1;
            end else begin
                sb_gnt = 1'b1;
            end
`endif
        end
    end

    assign rom_en   = sb_gnt | ke_gnt;
    assign rom_addr = sb_gnt ? sb_addr : (ke_gnt ? ke_addr : '0);
    assign busy     = |tag_vld;

`ifndef SBOX_ARB_KE_PRIORITY_EN
    // Pointer moves only on a grant; idle cycles leave it where it was.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_gnt <= OWN_SB;
        end else if (sb_gnt) begin
            last_gnt <= OWN_SB;
        end else if (ke_gnt) begin
            last_gnt <= OWN_KE;
        end
    end
`endif

    // Tags shift in lockstep with the ROM read pipeline so that the last
    // stage lines up with rom_data; the result is registered on that edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_vld   <= '0;
            tag_own   <= '0;
            sb_rvalid <= 1'b0;
            ke_rvalid <= 1'b0;
            sb_rdata  <= '0;
            ke_rdata  <= '0;
        end else begin
            tag_vld[0] <= rom_en;
            tag_own[0] <= ke_gnt;
            for (int i = 1; i < LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_own[i] <= tag_own[i-1];
            end

            sb_rvalid <= tag_vld[LATENCY-1] & ~tag_own[LATENCY-1];
            ke_rvalid <= tag_vld[LATENCY-1] &  tag_own[LATENCY-1];

            // Only the owner's result register moves; the other holds.
            if (tag_vld[LATENCY-1] && !tag_own[LATENCY-1]) begin
                sb_rdata <= rom_data;
            end
            if (tag_vld[LATENCY-1] && tag_own[LATENCY-1]) begin
                ke_rdata <= rom_data;
            end
        end
    end

endmodule

// File: tb/tb_sbox_arbiter.sv
// Purpose : self-checking bench for sbox_arbiter with an AES S-box ROM model.
// Latency : DUT built with LATENCY=2; ROM model has matching read latency.
// Backpres: stimulus holds requests until granted; results checked by a scoreboard monitor.
module tb_sbox_arbiter;

    localparam int LAT = 2;
    localparam int W   = 32;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         sb_req = 1'b0, ke_req = 1'b0;
    logic [W-1:0] sb_addr = '0, ke_addr = '0;
    logic         sb_gnt, ke_gnt, sb_rvalid, ke_rvalid, rom_en, busy;
    logic [W-1:0] sb_rdata, ke_rdata, rom_addr, rom_data;

    sbox_arbiter #(.LATENCY(LAT), .W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .sb_req   (sb_req),
        .sb_addr  (sb_addr),
        .sb_gnt   (sb_gnt),
        .sb_rvalid(sb_rvalid),
        .sb_rdata (sb_rdata),
        .ke_req   (ke_req),
        .ke_addr  (ke_addr),
        .ke_gnt   (ke_gnt),
        .ke_rvalid(ke_rvalid),
        .ke_rdata (ke_rdata),
        .rom_en   (rom_en),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM model: registered lookup followed by LAT-1 further delay stages.
    function automatic logic [31:0] sub4(input logic [31:0] a);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = SBOX[(255 - int'(a[8*i +: 8]))*8 +: 8];
        end
        return r;
    endfunction

    logic [W-1:0] rom_pipe [LAT];
    always @(posedge clk) begin
        rom_pipe[0] <= sub4(rom_addr);
        for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign rom_data = rom_pipe[LAT-1];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        ke_q[$];
    exp_t        sb_e, ke_e;
    logic [31:0] sb_last = '0, ke_last = '0;

    // Monitor: pops the scoreboard whenever a result pulses, checks data and
    // arrival cycle, and checks that the other port's result register held.
    always @(negedge clk) begin
        if (!rst) begin
            sb_last = '0;
            ke_last = '0;
        end else begin
            if (sb_rvalid) begin
                if (sb_q.size() == 0) begin
                    check("sb_rvalid unexpected", 32'd1, 32'd0);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("sb_rdata", sb_rdata, sb_e.data);
                    check("sb_rvalid cycle", cyc, sb_e.due);
                    sb_last = sb_e.data;
                end
                check("ke_rdata held", ke_rdata, ke_last);
            end else if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
                check("sb_rvalid missing", 32'd0, 32'd1);
                void'(sb_q.pop_front());
            end
            if (ke_rvalid) begin
                if (ke_q.size() == 0) begin
                    check("ke_rvalid unexpected", 32'd1, 32'd0);
                end else begin
                    ke_e = ke_q.pop_front();
                    check("ke_rdata", ke_rdata, ke_e.data);
                    check("ke_rvalid cycle", cyc, ke_e.due);
                    ke_last = ke_e.data;
                end
                check("sb_rdata held", sb_rdata, sb_last);
            end else if (ke_q.size() > 0 && ke_q[0].due < cyc) begin
                check("ke_rvalid missing", 32'd0, 32'd1);
                void'(ke_q.pop_front());
            end
        end
    end

    // One request cycle: drive (just after a rising edge), check grant and
    // ROM issue at the falling edge, queue the expected result, step to the
    // next rising edge.
    task automatic cycle_req(input string tag,
                             input logic sr, input logic [31:0] sa,
                             input logic kr, input logic [31:0] ka,
                             input logic exp_sb, input logic exp_ke,
                             input logic [31:0] sb_res, input logic [31:0] ke_res);
        sb_req  = sr;
        sb_addr = sa;
        ke_req  = kr;
        ke_addr = ka;
        @(negedge clk);
        check({tag, " sb_gnt"}, sb_gnt, exp_sb);
        check({tag, " ke_gnt"}, ke_gnt, exp_ke);
        check({tag, " rom_en"}, rom_en, exp_sb | exp_ke);
        check({tag, " rom_addr"}, rom_addr, exp_sb ? sa : (exp_ke ? ka : 32'h0));
        if (exp_sb) sb_q.push_back(exp_t'{sb_res, cyc + 1 + LAT});
        if (exp_ke) ke_q.push_back(exp_t'{ke_res, cyc + 1 + LAT});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cycle_req(tag, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    logic exp_ke_t2;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset sb_rvalid", sb_rvalid, 1'b0);
        check("reset ke_rvalid", ke_rvalid, 1'b0);
        check("reset sb_rdata", sb_rdata, 32'h0);
        check("reset ke_rdata", ke_rdata, 32'h0);
        check("reset busy", busy, 1'b0);
        check("reset rom_en", rom_en, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single SB lookup.
        cycle_req("t1", 1'b1, 32'h000153FF, 1'b0, 32'h0, 1'b1, 1'b0, 32'h637CED16, 32'h0);
        idle("t1 drain", LAT + 2);

        // Contention for 4 cycles, then KE drops and SB is served.
        for (int i = 0; i < 4; i++) begin
`ifdef SBOX_ARB_KE_PRIORITY_EN
            exp_ke_t2 = 1'b1;
`else
            exp_ke_t2 = (i % 2 == 0);
`endif
            cycle_req("t2 tie", 1'b1, 32'h00000000, 1'b1, 32'h01010101,
                      !exp_ke_t2, exp_ke_t2, 32'h63636363, 32'h7C7C7C7C);
        end
        cycle_req("t2 ke drop", 1'b1, 32'h00000000, 1'b0, 32'h0, 1'b1, 1'b0, 32'h63636363, 32'h0);
        idle("t2 drain", LAT + 2);

        // Three back-to-back SB lookups.
        cycle_req("t3 a", 1'b1, 32'h00010203, 1'b0, 32'h0, 1'b1, 1'b0, 32'h637C777B, 32'h0);
        check("t3 busy a", busy, 1'b1);
        cycle_req("t3 b", 1'b1, 32'h10203040, 1'b0, 32'h0, 1'b1, 1'b0, 32'hCAB70409, 32'h0);
        check("t3 busy b", busy, 1'b1);
        cycle_req("t3 c", 1'b1, 32'h50607080, 1'b0, 32'h0, 1'b1, 1'b0, 32'h53D051CD, 32'h0);
        check("t3 busy c", busy, 1'b1);
        idle("t3 drain", LAT + 2);
        check("t3 busy after drain", busy, 1'b0);

        // KE lookup, then reset while it is still in flight.
        cycle_req("t4", 1'b0, 32'h0, 1'b1, 32'h53535353, 1'b0, 1'b1, 32'h0, 32'hEDEDEDED);
        sb_req = 1'b0;
        ke_req = 1'b0;
        check("t4 busy in flight", busy, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        ke_q.delete();
        check("t4 rst sb_rvalid", sb_rvalid, 1'b0);
        check("t4 rst ke_rvalid", ke_rvalid, 1'b0);
        check("t4 rst sb_rdata", sb_rdata, 32'h0);
        check("t4 rst ke_rdata", ke_rdata, 32'h0);
        check("t4 rst busy", busy, 1'b0);
        check("t4 rst rom_en", rom_en, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        idle("t4 after release", LAT + 3);
        check("t4 busy after release", busy, 1'b0);

        // Load both result registers, then idle and confirm they hold.
        cycle_req("t5 sb", 1'b1, 32'h000153FF, 1'b0, 32'h0, 1'b1, 1'b0, 32'h637CED16, 32'h0);
        cycle_req("t5 ke", 1'b0, 32'h0, 1'b1, 32'h01010101, 1'b0, 1'b1, 32'h0, 32'h7C7C7C7C);
        idle("t5 drain", LAT + 2);
        for (int i = 0; i < 10; i++) begin
            idle("t6 idle", 1);
            check("t6 idle busy", busy, 1'b0);
        end
        check("t6 sb_rdata retained", sb_rdata, 32'h637CED16);
        check("t6 ke_rdata retained", ke_rdata, 32'h7C7C7C7C);

        check("sb scoreboard drained", sb_q.size(), 32'd0);
        check("ke scoreboard drained", ke_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
